div_hilo_ctrl: RTL and testbench

Sequencing and HI/LO commit stage wrapped around the 33-cycle iterative divider in EX. It accepts a DIV/DIVU request from the EX stage and latches the operands. It then launches the divider, holds its inputs stable, stalls the pipeline until the result is ready, and commits remainder→HI and quotient→LO at a single precise commit point. It also owns the architectural HI/LO registers, serves MTHI/MTLO writes, and aborts an in-flight divide on pipeline flush.

---
 rtl/div_hilo_ctrl_if.sv | 40 ++++
 rtl/div_hilo_ctrl.sv | 114 +++++++++++
 tb/tb_div_hilo_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_hilo_ctrl_if.sv
// Bundles the EX request, divider handshake and MTHI/MTLO write signals of the
// HI/LO divide control stage; the controller uses slave, its environment uses master.
interface div_hilo_ctrl_if;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        ex_flush;
  logic        stall;
  logic        done;
  logic        div_go;
  logic        div_signed_o;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_exception;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  modport slave (
    input  req_valid, req_signed, req_x, req_y, ex_flush,
    input  div_s, div_r, div_complete,
    input  wr_hi, wr_lo, wr_data,
    output stall, done, div_go, div_signed_o, div_x, div_y, div_exception,
    output hi_q, lo_q
  );

  modport master (
    output req_valid, req_signed, req_x, req_y, ex_flush,
    output div_s, div_r, div_complete,
    output wr_hi, wr_lo, wr_data,
    input  stall, done, div_go, div_signed_o, div_x, div_y, div_exception,
    input  hi_q, lo_q
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Sequences one DIV/DIVU through the 33-cycle iterative divider, stalls EX meanwhile,
// and commits remainder->HI / quotient->LO at a single point; also serves MTHI/MTLO.
module div_hilo_ctrl (
  input  logic           div_clk,
  input  logic           resetn,
  div_hilo_ctrl_if.slave dif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        latch_ops;
  logic        capture;
  logic        commit;

  logic [31:0] x_q;
  logic [31:0] y_q;
  logic        signed_q;
  logic [31:0] q_buf;
  logic [31:0] r_buf;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge div_clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: all outputs of this block get a default first, so no path holds a value and no latch is inferred.
    state_nxt = state;
    latch_ops = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    if (dif.ex_flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (dif.req_valid) begin
            latch_ops = 1'b1;
            state_nxt = S_LAUNCH;
          end
        end
        S_LAUNCH: state_nxt = S_WAIT;
        S_WAIT: begin
          if (dif.div_complete) begin
            capture   = 1'b1;
            state_nxt = S_RESP;
          end
        end
        S_RESP: begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Operands are frozen for the whole divide: the divider's sign fix-up reads them combinationally.
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      signed_q <= 1'b0;
    end else if (latch_ops) begin
      x_q      <= dif.req_x;
      y_q      <= dif.req_y;
      signed_q <= dif.req_signed;
    end
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      q_buf <= '0;
      r_buf <= '0;
    end else if (capture) begin
      q_buf <= dif.div_s;
      r_buf <= dif.div_r;
    end
  end

  // MTHI/MTLO can only reach this stage while it is idle; the stalled pipeline cannot issue them otherwise.
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit) begin
      hi_r <= r_buf;
      lo_r <= q_buf;
    end else if (state == S_IDLE) begin
      if (dif.wr_hi) hi_r <= dif.wr_data;
      if (dif.wr_lo) lo_r <= dif.wr_data;
    end
  end

  assign dif.div_go        = (state == S_LAUNCH);
  assign dif.done          = (state == S_RESP);
  assign dif.div_exception = dif.ex_flush;
  assign dif.stall         = dif.req_valid & (state != S_RESP) & ~dif.ex_flush;
  assign dif.div_x         = x_q;
  assign dif.div_y         = y_q;
  assign dif.div_signed_o  = signed_q;
  assign dif.hi_q          = hi_r;
  assign dif.lo_q          = lo_r;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: a 33-cycle divider stand-in, a cycle-timeline reference
// model compared every cycle, and directed divides with hand-computed HI/LO values.
module tb_div_hilo_ctrl;

  logic div_clk = 1'b0;
  logic resetn;
  div_hilo_ctrl_if dif ();

  div_hilo_ctrl dut (
    .div_clk (div_clk),
    .resetn  (resetn),
    .dif     (dif)
  );

  always #5 div_clk = ~div_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic divide; returns {quotient, remainder}. Divide-by-zero gives all-ones / dividend.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic [31:0] q;
    logic [31:0] r;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {q, r};
  endfunction

  // Divider stand-in: starts on div_go, result valid 33 cycles later, aborted by div_exception.
  logic       dv_busy;
  logic [5:0] dv_cnt;
  logic       stray_complete;
  logic [63:0] dv_qr;

  always @(posedge div_clk) begin
    if (!resetn || dif.div_exception) begin
      dv_busy <= 1'b0;
      dv_cnt  <= '0;
    end else if (dv_busy) begin
      if (dv_cnt == 6'd32) begin
        dv_busy <= 1'b0;
        dv_cnt  <= '0;
      end else begin
        dv_cnt <= dv_cnt + 6'd1;
      end
    end else if (dif.div_go) begin
      dv_busy <= 1'b1;
      dv_cnt  <= '0;
    end
  end

  always_comb begin
    dv_qr            = ref_div(dif.div_signed_o, dif.div_x, dif.div_y);
    dif.div_complete = (dv_busy && dv_cnt == 6'd32) || stray_complete;
    dif.div_s        = (dv_busy && dv_cnt == 6'd32) ? dv_qr[63:32] : 32'hDEAD_BEEF;
    dif.div_r        = (dv_busy && dv_cnt == 6'd32) ? dv_qr[31:0]  : 32'hBADC_0FFE;
  end

  // Reference model: cycle index k since the request cycle C0; go in C1, done/commit in C35.
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [31:0] m_x = '0;
  logic [31:0] m_y = '0;
  logic        m_sgn = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_qr;

  always @(negedge div_clk) begin
    check("cmp_stall", dif.stall, dif.req_valid && !(m_active && m_k == 35) && !dif.ex_flush);
    check("cmp_done", dif.done, m_active && m_k == 35);
    check("cmp_div_go", dif.div_go, m_active && m_k == 1);
    check("cmp_div_exception", dif.div_exception, dif.ex_flush);
    check("cmp_div_x", dif.div_x, m_x);
    check("cmp_div_y", dif.div_y, m_y);
    check("cmp_div_signed", dif.div_signed_o, m_sgn);
    check("cmp_hi", dif.hi_q, m_hi);
    check("cmp_lo", dif.lo_q, m_lo);

    if (!resetn) begin
      m_active = 1'b0;
      m_k      = 0;
      m_x      = '0;
      m_y      = '0;
      m_sgn    = 1'b0;
      m_hi     = '0;
      m_lo     = '0;
    end else if (!m_active) begin
      if (dif.wr_hi) m_hi = dif.wr_data;
      if (dif.wr_lo) m_lo = dif.wr_data;
      if (dif.req_valid && !dif.ex_flush) begin
        m_active = 1'b1;
        m_k      = 1;
        m_x      = dif.req_x;
        m_y      = dif.req_y;
        m_sgn    = dif.req_signed;
      end
    end else if (dif.ex_flush) begin
      m_active = 1'b0;
    end else if (m_k == 35) begin
      m_qr     = ref_div(m_sgn, m_x, m_y);
      m_hi     = m_qr[31:0];
      m_lo     = m_qr[63:32];
      m_active = 1'b0;
    end else begin
      m_k++;
    end
  end

  // Issues one request and follows it until done, flush, or a 60-cycle bound; req_* are
  // scrambled after C1 so any operand that tracks the request lines shows up.
  task automatic run_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         input int flush_at, output int stall_cycles, output int done_at,
                         output logic exc_seen, output logic [31:0] hi_after,
                         output logic [31:0] lo_after);
    dif.req_valid  = 1'b1;
    dif.req_signed = sgn;
    dif.req_x      = x;
    dif.req_y      = y;
    stall_cycles   = 0;
    done_at        = -1;
    exc_seen       = 1'b0;
    for (int c = 0; c < 60; c++) begin
      dif.ex_flush = (c == flush_at);
      @(negedge div_clk);
      if (dif.stall) stall_cycles++;
      if (dif.done) done_at = c;
      if (c == flush_at) exc_seen = dif.div_exception;
      @(posedge div_clk);
      #1;
      dif.ex_flush = 1'b0;
      if (done_at >= 0 || c == flush_at) break;
      if (c >= 1) begin
        dif.req_x      = x ^ 32'hA5A5_0F0F;
        dif.req_y      = y ^ 32'h0F0F_A5A5;
        dif.req_signed = ~sgn;
      end
    end
    dif.req_valid = 1'b0;
    hi_after = dif.hi_q;
    lo_after = dif.lo_q;
  endtask

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  int          st;
  int          dn;
  logic        ex;
  logic [31:0] hi;
  logic [31:0] lo;

  initial begin
    resetn         = 1'b0;
    stray_complete = 1'b0;
    dif.req_valid  = 1'b0;
    dif.req_signed = 1'b0;
    dif.req_x      = '0;
    dif.req_y      = '0;
    dif.ex_flush   = 1'b0;
    dif.wr_hi      = 1'b0;
    dif.wr_lo      = 1'b0;
    dif.wr_data    = '0;

    // Reset state
    tick();
    dif.req_valid = 1'b1;
    #1;
    check("rst_hi", dif.hi_q, 32'h0);
    check("rst_lo", dif.lo_q, 32'h0);
    check("rst_div_go", dif.div_go, 1'b0);
    check("rst_done", dif.done, 1'b0);
    check("rst_stall_req", dif.stall, 1'b1);
    dif.ex_flush = 1'b1;
    #1;
    check("rst_stall_flush", dif.stall, 1'b0);
    check("rst_exception", dif.div_exception, 1'b1);
    dif.req_valid = 1'b0;
    dif.ex_flush  = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // DIVU 100/7
    run_div(1'b0, 32'd100, 32'd7, -1, st, dn, ex, hi, lo);
    check("divu100_stall_len", st, 35);
    check("divu100_done_cycle", dn, 35);
    check("divu100_hi", hi, 32'd2);
    check("divu100_lo", lo, 32'd14);

    // DIV -7/2, then DIVU back-to-back in C36
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, st, dn, ex, hi, lo);
    check("divm7_hi", hi, 32'hFFFF_FFFF);
    check("divm7_lo", lo, 32'hFFFF_FFFD);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, -1, st, dn, ex, hi, lo);
    check("b2b_stall_len", st, 35);
    check("b2b_hi", hi, 32'h0000_000F);
    check("b2b_lo", lo, 32'h0FFF_FFFF);

    // Divide by zero
    run_div(1'b0, 32'h1234, 32'd0, -1, st, dn, ex, hi, lo);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'hFFFF_FFFF);

    // Flush in WAIT (C20), then a fresh DIVU 9/4
    run_div(1'b1, 32'd100, 32'd7, 20, st, dn, ex, hi, lo);
    check("flush20_exception", ex, 1'b1);
    check("flush20_done", dn, -1);
    check("flush20_hi", hi, 32'h1234);
    check("flush20_lo", lo, 32'hFFFF_FFFF);
    run_div(1'b0, 32'd9, 32'd4, -1, st, dn, ex, hi, lo);
    check("divu9_stall_len", st, 35);
    check("divu9_done_cycle", dn, 35);
    check("divu9_hi", hi, 32'd1);
    check("divu9_lo", lo, 32'd2);

    // Flush coinciding with div_complete, then flush in RESP
    run_div(1'b0, 32'd50, 32'd3, 34, st, dn, ex, hi, lo);
    check("flush_cmpl_done", dn, -1);
    check("flush_cmpl_hi", hi, 32'd1);
    check("flush_cmpl_lo", lo, 32'd2);
    run_div(1'b0, 32'd60, 32'd7, 35, st, dn, ex, hi, lo);
    check("flush_resp_done", dn, 35);
    check("flush_resp_hi", hi, 32'd1);
    check("flush_resp_lo", lo, 32'd2);

    // Flush in LAUNCH, then a normal divide
    run_div(1'b0, 32'd20, 32'd3, 1, st, dn, ex, hi, lo);
    check("flush_launch_exception", ex, 1'b1);
    run_div(1'b0, 32'd20, 32'd3, -1, st, dn, ex, hi, lo);
    check("divu20_stall_len", st, 35);
    check("divu20_hi", hi, 32'd2);
    check("divu20_lo", lo, 32'd6);

    // Stray div_complete while idle
    stray_complete = 1'b1;
    tick();
    stray_complete = 1'b0;
    check("stray_done", dif.done, 1'b0);
    check("stray_hi", dif.hi_q, 32'd2);
    check("stray_lo", dif.lo_q, 32'd6);

    // MTHI / MTLO
    dif.wr_hi   = 1'b1;
    dif.wr_data = 32'hA5A5_A5A5;
    tick();
    dif.wr_hi = 1'b0;
    check("mthi_hi", dif.hi_q, 32'hA5A5_A5A5);
    check("mthi_lo", dif.lo_q, 32'd6);
    dif.wr_lo   = 1'b1;
    dif.wr_data = 32'h5A5A_5A5A;
    tick();
    dif.wr_lo = 1'b0;
    check("mtlo_hi", dif.hi_q, 32'hA5A5_A5A5);
    check("mtlo_lo", dif.lo_q, 32'h5A5A_5A5A);
    dif.wr_hi   = 1'b1;
    dif.wr_lo   = 1'b1;
    dif.wr_data = 32'h3C3C_3C3C;
    tick();
    dif.wr_hi = 1'b0;
    dif.wr_lo = 1'b0;
    check("mtboth_hi", dif.hi_q, 32'h3C3C_3C3C);
    check("mtboth_lo", dif.lo_q, 32'h3C3C_3C3C);

    // wr_hi during WAIT is ignored; reset in WAIT clears everything
    dif.req_valid  = 1'b1;
    dif.req_signed = 1'b0;
    dif.req_x      = 32'd100;
    dif.req_y      = 32'd7;
    for (int c = 0; c < 16; c++) begin
      dif.wr_hi   = (c == 10);
      dif.wr_data = 32'hFFFF_0000;
      resetn      = (c != 15);
      @(negedge div_clk);
      if (c == 11) check("wait_wr_hi_ignored", dif.hi_q, 32'h3C3C_3C3C);
      tick();
    end
    dif.wr_hi = 1'b0;
    resetn    = 1'b1;
    check("midrst_hi", dif.hi_q, 32'h0);
    check("midrst_lo", dif.lo_q, 32'h0);
    check("midrst_div_go", dif.div_go, 1'b0);
    check("midrst_stall_req", dif.stall, 1'b1);
    dif.req_valid = 1'b0;
    #1;
    check("midrst_stall_idle", dif.stall, 1'b0);
    tick();

    // Divide after reset
    run_div(1'b0, 32'd100, 32'd7, -1, st, dn, ex, hi, lo);
    check("post_rst_stall_len", st, 35);
    check("post_rst_hi", hi, 32'd2);
    check("post_rst_lo", lo, 32'd14);

    tick();
    tick();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
